mux_n_reg: RTL
==============

# mux_n_reg

Parametrised N-input, registered select stage with valid/ready flow control and a one-entry skid buffer. It is the pipelined successor of the fixed 3-input combinational mux used in the datapath. It sits between pipeline stages, for example to select the ALU operand source from register file, forwarded EX or forwarded MEM data. Stalls and flushes are absorbed without a combinational ready path.

## Interface
Parameters:
- WIDTH, 32, data width of each input and the output
- N, 3, number of inputs; legal range 2..16
- SEL_W, $clog2(N), select width; derived, never overridden

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_data  in  N*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
- sel  in  SEL_W  input index, sampled with the beat
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat
- out_data  out  WIDTH  registered selected data
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts the beat
- flush  in  1  synchronous discard of all held beats
- sel_err  out  1  present only with MUX_N_SEL_ERR_EN; see Configuration

## Operation
- Accept: a beat transfers when in_valid && in_ready. Its value is in_data[sel], or all-zero if sel >= N.
- Storage:
  - main register (out_data/out_valid)
  - skid register (skid_data/skid_valid)
- in_ready = ~skid_valid && rst_n. It is derived from a register only, with no path from out_ready.
- State (encoded by the valid bits):
  - EMPTY (0/0)
  - ONE (main valid)
  - FULL (main and skid valid)
- Transitions:
  - EMPTY, accept → ONE; the beat is loaded into main.
  - ONE, accept and out_ready → ONE; main is replaced with the new beat.
  - ONE, accept and !out_ready → FULL; the new beat is loaded into skid.
  - ONE, out_ready and no accept → EMPTY.
  - FULL, out_ready → ONE; skid moves to main. No accept is possible because in_ready is 0.
  - FULL, !out_ready → hold.
- While out_valid && !out_ready, out_data is held stable.
- flush has priority over every transfer. On the next edge out_valid=0 and skid_valid=0. A beat accepted in the flush cycle is discarded. Data registers are not cleared.
- Simultaneous flush and reset: reset wins. The outcome is identical anyway.

## Timing
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 beat/cycle while out_ready stays high.
- Reset values (at the first edge with rst_n=0):
  - out_valid=0, out_data=0
  - skid_valid=0, skid_data=0
  - sel_err=0
  - in_ready=0 while rst_n=0 and 1 from the first cycle after release.
- Reset mid-operation discards held beats. No partial output is produced.
- in_ready falls exactly one cycle after the accept that fills skid. It rises one cycle after the out_ready handshake that drains skid.

## Configuration
- MUX_N_SEL_ERR_EN defined:
  - The sel_err port exists.
  - It goes high on the edge after any accepted beat with sel >= N.
  - It is sticky until reset. flush does not clear it.
  - The zeroed beat is still forwarded.
- Not defined: the sel_err port and its logic are absent. Out-of-range selects silently produce zero.

## Structure
- Package mux_n_pkg holds:
  - DEFAULT_WIDTH=32, DEFAULT_N=3, MAX_N=16
  - the state-encoding typedef enum {EMPTY, ONE, FULL} (used for assertions and debug)
  - the function sel_width(n)
- Sub-module mux_n_comb: purely combinational N-way select with zero for out-of-range. mux_n_reg instantiates it once in front of the registers.

## Test plan
All scenarios use N=3, WIDTH=32, inputs 10/20/30.
1. Reset hold: rst_n=0 for 3 cycles, then released → out_valid=0, out_data=0, in_ready=0 during reset; in_ready=1 on the cycle after release.
2. Streaming: out_ready=1, in_valid=1, sel=0,1,2 on consecutive cycles → out_data=10,20,30 one cycle later each, out_valid continuous.
3. Backpressure: out_ready=0 with beats sel=1 then sel=2 → out_data holds 20, in_ready drops after the second accept. Raising out_ready then gives 20, then 30, no loss or duplication, in_ready=1 again.
4. Out-of-range: sel=3 accepted → out_data=0. With MUX_N_SEL_ERR_EN, sel_err=1 and stays 1 through later valid beats until reset.
5. Flush in FULL: two beats held, flush=1 with in_valid=1 sel=0 in the same cycle → next cycle out_valid=0, in_ready=1, the sel=0 beat never appears.
6. Reset mid-stream: rst_n=0 while FULL → next cycle out_valid=0, out_data=0; after release a sel=2 beat yields 30 with 1-cycle latency.

Source files
------------

// File: rtl/mux_n_pkg.sv
// Shared defaults, occupancy encoding and select-width helper for the
// registered N-way select stage.
package mux_n_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_N     = 3;
  localparam int MAX_N         = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // Two inputs still need one select bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Combinational N-way select; any select value at or beyond N yields zero.
module mux_n_comb
  import mux_n_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int N     = DEFAULT_N,
  localparam int SEL_W = sel_width(N)
) (
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   sel,
  output logic [WIDTH-1:0]   data
);

  always_comb begin
    data = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) data = in_data[k*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/mux_n_reg.sv
// Registered N-way select with valid/ready and a one-entry skid buffer.
// Optional macro MUX_N_SEL_ERR_EN adds a sticky out-of-range select flag (sel_err).
//
//   state | meaning
//   EMPTY | nothing held; main and skid invalid
//   ONE   | main register holds the beat presented downstream
//   FULL  | main held and stalled, skid holds the next beat; in_ready low
module mux_n_reg
  import mux_n_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int N     = DEFAULT_N,
  localparam int SEL_W = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               flush
`ifdef MUX_N_SEL_ERR_EN
  ,
  output logic               sel_err
`endif
);

  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] skid_data;
  logic             skid_valid;
  logic             accept;
  state_t           state;

  mux_n_comb #(
    .WIDTH (WIDTH),
    .N     (N)
  ) u_comb (
    .in_data (in_data),
    .sel     (sel),
    .data    (sel_data)
  );

  // Ready comes from the skid flag only, so out_ready never reaches in_ready.
  assign in_ready = ~skid_valid && rst_n;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state = EMPTY;
    if (skid_valid)     state = FULL;
    else if (out_valid) state = ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_data  <= sel_data;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (accept && out_ready) begin
            out_data <= sel_data;
          end else if (accept) begin
            skid_data  <= sel_data;
            skid_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        FULL: begin
          if (out_ready) begin
            out_data   <= skid_data;
            skid_valid <= 1'b0;
          end
        end
        default: begin
          out_valid  <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef MUX_N_SEL_ERR_EN
  logic sel_oob;
  assign sel_oob = (32'(sel) >= 32'(N));

  // Set on any handshake with a bad select, including one later flushed.
  always_ff @(posedge clk) begin
    if (!rst_n)                 sel_err <= 1'b0;
    else if (accept && sel_oob) sel_err <= 1'b1;
  end
`endif

  a_hold_stable : assert property (@(posedge clk) disable iff (!rst_n)
    out_valid && !out_ready && !flush |=> out_valid && $stable(out_data));

  a_skid_needs_main : assert property (@(posedge clk) disable iff (!rst_n)
    skid_valid |-> out_valid);

  a_flush_empties : assert property (@(posedge clk) disable iff (!rst_n)
    flush |=> !out_valid && !skid_valid);

endmodule
